// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback arbiter requester, regfile-write and scoreboard bundle
interface wb_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PREG_W     = 6
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*PREG_W-1:0]     req_preg_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          flush_i;
  logic                          alloc_en_i;
  logic [PREG_W-1:0]             alloc_preg_i;
  logic                          wr1_en_o;
  logic                          wr2_en_o;
  logic [PREG_W-1:0]             wr1_preg_o;
  logic [PREG_W-1:0]             wr2_preg_o;
  logic [DATA_WIDTH-1:0]         wr1_data_o;
  logic [DATA_WIDTH-1:0]         wr2_data_o;
  logic [(2**PREG_W)-1:0]        preg_ready_o;

  modport master (
    output req_valid_i, req_preg_i, req_data_i, flush_i, alloc_en_i, alloc_preg_i,
    input  req_ready_o, wr1_en_o, wr2_en_o, wr1_preg_o, wr2_preg_o,
    input  wr1_data_o, wr2_data_o, preg_ready_o
  );

  modport slave (
    input  req_valid_i, req_preg_i, req_data_i, flush_i, alloc_en_i, alloc_preg_i,
    output req_ready_o, wr1_en_o, wr2_en_o, wr1_preg_o, wr2_preg_o,
    output wr1_data_o, wr2_data_o, preg_ready_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-port round-robin writeback arbiter with preg scoreboard (optional WAW_GUARD_EN)
module wb_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PREG_W     = 6
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NPREG = 2 ** PREG_W;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_next;
  logic                  gnt_a_vld;
  logic                  gnt_b_vld;
  logic [PTR_W-1:0]      gnt_a_idx;
  logic [PTR_W-1:0]      gnt_b_idx;
  logic [PREG_W-1:0]     preg_a;
  logic [PREG_W-1:0]     preg_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [NUM_REQ-1:0]    grant;
  logic [NPREG-1:0]      ready_q;
  logic [NPREG-1:0]      ready_next;

  // Scan upward from rr_ptr: first valid requester is grant A, the next one grant B
  always_comb begin
    gnt_a_vld = 1'b0;
    gnt_b_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_b_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid_i[idx]) begin
        if (!gnt_a_vld) begin
          gnt_a_vld = 1'b1;
          gnt_a_idx = PTR_W'(idx);
        end else if (!gnt_b_vld) begin
          gnt_b_vld = 1'b1;
          gnt_b_idx = PTR_W'(idx);
        end
      end
    end
    // Nothing is granted during reset so a held request survives until release
    if (rst) begin
      gnt_a_vld = 1'b0;
      gnt_b_vld = 1'b0;
    end
    preg_a = bus.req_preg_i[int'(gnt_a_idx)*PREG_W +: PREG_W];
    preg_b = bus.req_preg_i[int'(gnt_b_idx)*PREG_W +: PREG_W];
    data_a = bus.req_data_i[int'(gnt_a_idx)*DATA_WIDTH +: DATA_WIDTH];
    data_b = bus.req_data_i[int'(gnt_b_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef WAW_GUARD_EN
    // Two writes to the same preg in one cycle: hold B back for a later cycle
    if (gnt_b_vld && (preg_b == preg_a)) gnt_b_vld = 1'b0;
`endif
    grant = '0;
    if (gnt_a_vld) grant[gnt_a_idx] = 1'b1;
    if (gnt_b_vld) grant[gnt_b_idx] = 1'b1;
    bus.req_ready_o = grant;
  end

  // Pointer moves one past the last requester granted this cycle
  always_comb begin
    rr_next = rr_ptr;
    if (gnt_b_vld) begin
      rr_next = (gnt_b_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_b_idx + 1'b1;
    end else if (gnt_a_vld) begin
      rr_next = (gnt_a_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_a_idx + 1'b1;
    end
  end

  // Scoreboard: set on committed writes, then alloc clears (clear wins), preg 0 always ready
  always_comb begin
    ready_next = ready_q;
    if (!bus.flush_i) begin
      if (gnt_a_vld && (preg_a != '0)) ready_next[preg_a] = 1'b1;
      if (gnt_b_vld && (preg_b != '0)) ready_next[preg_b] = 1'b1;
    end
    if (bus.alloc_en_i) ready_next[bus.alloc_preg_i] = 1'b0;
    ready_next[0] = 1'b1;
  end

  // Register pointer, scoreboard and the two regfile write ports
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      ready_q        <= '1;
      bus.wr1_en_o   <= 1'b0;
      bus.wr1_preg_o <= '0;
      bus.wr1_data_o <= '0;
      bus.wr2_en_o   <= 1'b0;
      bus.wr2_preg_o <= '0;
      bus.wr2_data_o <= '0;
    end else begin
      rr_ptr         <= rr_next;
      ready_q        <= ready_next;
      bus.wr1_en_o   <= gnt_a_vld && !bus.flush_i && (preg_a != '0);
      bus.wr1_preg_o <= gnt_a_vld ? preg_a : '0;
      bus.wr1_data_o <= gnt_a_vld ? data_a : '0;
      bus.wr2_en_o   <= gnt_b_vld && !bus.flush_i && (preg_b != '0);
      bus.wr2_preg_o <= gnt_b_vld ? preg_b : '0;
      bus.wr2_data_o <= gnt_b_vld ? data_b : '0;
    end
  end

  assign bus.preg_ready_o = ready_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed check of wb_port_arbiter against a reference model
module tb_wb_port_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int PREG_W     = 6;
  localparam int NPREG      = 2 ** PREG_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .PREG_W(PREG_W)) bus ();

  wb_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .PREG_W(PREG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic                  r_valid [NUM_REQ];
  logic [PREG_W-1:0]     r_preg  [NUM_REQ];
  logic [DATA_WIDTH-1:0] r_data  [NUM_REQ];
  logic                  flush;
  logic                  alloc_en;
  logic [PREG_W-1:0]     alloc_preg;

  int                    m_rr;
  logic [NPREG-1:0]      m_ready;
  logic                  m_en   [2];
  logic [PREG_W-1:0]     m_preg [2];
  logic [DATA_WIDTH-1:0] m_data [2];
  int                    ga;
  int                    gb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_rr    = 0;
    m_ready = '1;
    for (int p = 0; p < 2; p++) begin
      m_en[p]   = 1'b0;
      m_preg[p] = '0;
      m_data[p] = '0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid_i[i]                           = r_valid[i];
      bus.req_preg_i[i*PREG_W +: PREG_W]           = r_preg[i];
      bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH]   = r_data[i];
    end
    bus.flush_i      = flush;
    bus.alloc_en_i   = alloc_en;
    bus.alloc_preg_i = alloc_preg;
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model across the edge
  task automatic step();
    int               order[$];
    int               g[2];
    logic [NUM_REQ-1:0] exp_rdy;
    apply();
    #1;
    ga = -1;
    gb = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (r_valid[(m_rr + k) % NUM_REQ]) order.push_back((m_rr + k) % NUM_REQ);
      if (order.size() > 0) ga = order[0];
      if (order.size() > 1) gb = order[1];
`ifdef WAW_GUARD_EN
      if (gb >= 0 && r_preg[gb] == r_preg[ga]) gb = -1;
`endif
    end
    exp_rdy = '0;
    if (ga >= 0) exp_rdy[ga] = 1'b1;
    if (gb >= 0) exp_rdy[gb] = 1'b1;
    check_eq("req_ready",  bus.req_ready_o, exp_rdy);
    check_eq("wr1_en",     bus.wr1_en_o,    m_en[0]);
    check_eq("wr1_preg",   bus.wr1_preg_o,  m_preg[0]);
    check_eq("wr1_data",   bus.wr1_data_o,  m_data[0]);
    check_eq("wr2_en",     bus.wr2_en_o,    m_en[1]);
    check_eq("wr2_preg",   bus.wr2_preg_o,  m_preg[1]);
    check_eq("wr2_data",   bus.wr2_data_o,  m_data[1]);
    check_eq("preg_ready", bus.preg_ready_o, m_ready);
    if (rst) begin
      reset_model();
    end else begin
      g[0] = ga;
      g[1] = gb;
      for (int p = 0; p < 2; p++) begin
        if (g[p] >= 0) begin
          m_en[p]   = !flush && (r_preg[g[p]] != 0);
          m_preg[p] = r_preg[g[p]];
          m_data[p] = r_data[g[p]];
          if (!flush && r_preg[g[p]] != 0) m_ready[r_preg[g[p]]] = 1'b1;
        end else begin
          m_en[p]   = 1'b0;
          m_preg[p] = '0;
          m_data[p] = '0;
        end
      end
      if (alloc_en && alloc_preg != 0) m_ready[alloc_preg] = 1'b0;
      if (gb >= 0)      m_rr = (gb + 1) % NUM_REQ;
      else if (ga >= 0) m_rr = (ga + 1) % NUM_REQ;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [PREG_W-1:0] pick_preg();
    if ($urandom_range(0, 3) == 0) return PREG_W'($urandom_range(0, NPREG - 1));
    return PREG_W'($urandom_range(0, 15));
  endfunction

  // Granted requesters drop; in random mode idle requesters may raise a new request
  task automatic retire(input bit rnd);
    if (ga >= 0) r_valid[ga] = 1'b0;
    if (gb >= 0) r_valid[gb] = 1'b0;
    if (rnd) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!r_valid[i] && $urandom_range(0, 1) == 1) begin
          r_valid[i] = 1'b1;
          r_preg[i]  = pick_preg();
          r_data[i]  = $urandom;
        end
      end
      flush      = ($urandom_range(0, 7) == 0);
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_preg = pick_preg();
      rst        = ($urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    alloc_en   = 1'b0;
    alloc_preg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_valid[i] = 1'b0;
      r_preg[i]  = '0;
      r_data[i]  = '0;
    end
    apply();
    repeat (2) @(posedge clk);
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    step();

    // Four requesters, pregs 5..8: pairs (0,1) then (2,3)
    for (int i = 0; i < NUM_REQ; i++) begin
      r_valid[i] = 1'b1;
      r_preg[i]  = PREG_W'(5 + i);
      r_data[i]  = $urandom;
    end
    step(); retire(0);
    step(); retire(0);
    step();

    // Allocate preg 9, then write it from requester 2
    alloc_en = 1'b1; alloc_preg = 6'd9;
    step();
    alloc_en = 1'b0;
    r_valid[2] = 1'b1; r_preg[2] = 6'd9; r_data[2] = 32'hDEADBEEF;
    step(); retire(0);
    step();

    // Write and alloc of preg 12 in the same cycle: clear wins
    r_valid[0] = 1'b1; r_preg[0] = 6'd12; r_data[0] = $urandom;
    alloc_en = 1'b1; alloc_preg = 6'd12;
    step(); retire(0);
    alloc_en = 1'b0;
    step();

    // Flush with two grants
    r_valid[1] = 1'b1; r_preg[1] = 6'd20; r_data[1] = $urandom;
    r_valid[3] = 1'b1; r_preg[3] = 6'd21; r_data[3] = $urandom;
    flush = 1'b1;
    step(); retire(0);
    flush = 1'b0;
    step();

    // Two requesters writing the same preg 3
    r_valid[0] = 1'b1; r_preg[0] = 6'd3; r_data[0] = $urandom;
    r_valid[1] = 1'b1; r_preg[1] = 6'd3; r_data[1] = $urandom;
    step(); retire(0);
    step(); retire(0);
    step();

    // Reset asserted while a request is pending
    r_valid[2] = 1'b1; r_preg[2] = 6'd30; r_data[2] = $urandom;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); retire(0);
    step();

    // Random traffic
    repeat (2000) begin
      retire(1);
      step();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL provide parameters: NUM_REQ, default 4, number of writeback requesters; DATA_WIDTH, default 32, result width; PREG_W, default 6, physical-register index width.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester result valid
- req_preg_i  in  NUM_REQ*PREG_W  destination preg per requester (packed, requester 0 in LSBs)
- req_data_i  in  NUM_REQ*DATA_WIDTH  result per requester (packed)
- req_ready_o  out  NUM_REQ  grant (combinational)
- flush_i  in  1  squash writes registered this cycle
- alloc_en_i  in  1  rename allocates a preg
- alloc_preg_i  in  PREG_W  allocated preg
- wr1_en_o, wr2_en_o  out  1 each  regfile write enables (registered)
- wr1_preg_o, wr2_preg_o  out  PREG_W each  write address (registered)
- wr1_data_o, wr2_data_o  out  DATA_WIDTH each  write data (registered)
- preg_ready_o  out  2^PREG_W  scoreboard, bit p = preg p holds its final value

Function
REQ-003 SHALL use a valid/ready handshake: a transfer occurs in a cycle where req_valid_i[i] and req_ready_o[i] are both high; requester holds valid, preg and data stable until it does.
REQ-004 SHALL grant at most two requesters per cycle; req_ready_o[i] SHALL never be high while req_valid_i[i] is low.
REQ-005 SHALL select grant A as the first valid requester scanning upward from rr_ptr modulo NUM_REQ, and grant B as the next valid requester after A in the same scan.
REQ-006 SHALL route grant A to port 1 and grant B to port 2; a cycle with only one grant uses port 1 only.
REQ-007 SHALL advance rr_ptr to (index of last grant in the cycle + 1) mod NUM_REQ; with no grant, rr_ptr SHALL be unchanged.
REQ-008 SHALL register granted preg/data on the clock edge ending grant cycle N; wr*_en_o high throughout cycle N+1 (latency 1); ports with no grant SHALL drive en=0, preg=0, data=0.
REQ-009 SHALL suppress wr*_en_o (drive 0) for a grant whose preg equals 0; the transfer still completes.
REQ-010 SHALL, when flush_i is high in cycle N, still grant normally but register wr1_en_o=wr2_en_o=0 for cycle N+1 and skip the scoreboard update; rr_ptr still advances.
REQ-011 SHALL set preg_ready_o[p] at the edge ending cycle N for each non-flushed, nonzero preg p granted in N, so it is visible in N+1 alongside the write.
REQ-012 SHALL clear preg_ready_o[alloc_preg_i] at the edge ending any cycle with alloc_en_i high; on the same preg in the same cycle, the clear SHALL win over the set.
REQ-013 SHALL keep preg_ready_o[0] at 1 permanently; alloc of preg 0 SHALL be ignored.

Reset
REQ-014 SHALL, while rst is high at a clock edge, set rr_ptr=0, all wr*_en/preg/data outputs to 0, and every preg_ready_o bit to 1.
REQ-015 SHALL hold req_ready_o at all-zero while rst is high, including rst asserted mid-transfer; the held request SHALL be granted after reset release.

Configuration
REQ-016 SHALL implement macro WAW_GUARD_EN: when defined, if grant B's preg equals grant A's preg, B SHALL be withheld (req_ready_o low) and retried next cycle; rr_ptr advances past A only.
REQ-017 SHALL, without WAW_GUARD_EN, grant both; the regfile receives both writes with the same address in the same cycle, port 1 taking precedence.

Verification
REQ-018 Reset, then idle: preg_ready_o all ones, wr1_en_o=wr2_en_o=0, req_ready_o=0.
REQ-019 rr_ptr=0, valid=4'b1111, pregs 5,6,7,8: cycle 0 grants 0->port1 and 1->port2; cycle 1 grants 2 and 3; wr ports show preg 5/6 data in cycle 1 and 7/8 in cycle 2.
REQ-020 alloc preg 9 (ready[9]=0), then requester 2 writes preg 9 data 0xDEADBEEF: wr1_en_o=1, wr1_preg_o=9 next cycle, ready[9]=1 in the same cycle.
REQ-021 Same-cycle grant to preg 12 plus alloc_en_i of preg 12: ready[12]=0 next cycle; write still issued on port 1.
REQ-022 flush_i high with two valid grants: both transfers complete, wr*_en_o=0 next cycle, ready bits unchanged.
REQ-023 WAW_GUARD_EN defined, requesters 0 and 1 both target preg 3: only requester 0 granted in cycle 0, requester 1 in cycle 1; undefined: both granted in cycle 0.
